// File: rtl/csr_trap_seq.sv
// Trap-entry / mret-exit sequencer owning the clint write port of the CSR file.
// Latency: trap = accept + 3 writes + redirect (ack 4 cycles after accept); mret = accept + 1 write + redirect.
// Backpressure: any write cycle that collides with an ex-port write stalls one cycle; redirect never stalls.
// Optional feature: define CSR_TRAP_VECTORED_EN for vectored interrupt targets (mtvec mode 01).
module csr_trap_seq #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trap_req_i,
  input  logic [DataWidth-1:0] trap_cause_i,
  input  logic [DataWidth-1:0] trap_pc_i,
  input  logic                 mret_req_i,
  input  logic                 ex_csr_we_i,
  input  logic [DataWidth-1:0] csr_mtvec_i,
  input  logic [DataWidth-1:0] csr_mepc_i,
  input  logic [DataWidth-1:0] csr_mstatus_i,
  output logic                 csr_we_o,
  output logic [AddrWidth-1:0] csr_waddr_o,
  output logic [DataWidth-1:0] csr_wdata_o,
  output logic                 busy_o,
  output logic                 ack_o,
  output logic                 redirect_o,
  output logic [DataWidth-1:0] redirect_pc_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_T_MEPC    = 3'd1;
  localparam logic [2:0] S_T_MCAUSE  = 3'd2;
  localparam logic [2:0] S_T_MSTATUS = 3'd3;
  localparam logic [2:0] S_M_MSTATUS = 3'd4;
  localparam logic [2:0] S_REDIR     = 3'd5;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [2:0]           r_state;
  logic [DataWidth-1:0] r_cause;
  logic [DataWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_redir_pc;

  logic                 w_write_state;
  logic                 w_issue;
  logic [DataWidth-1:0] w_ms_trap;
  logic [DataWidth-1:0] w_ms_mret;
  logic [DataWidth-1:0] w_mtvec_base;
  logic [DataWidth-1:0] w_trap_tgt;
  logic [11:0]          w_addr;
  logic [DataWidth-1:0] w_data;

  // A write issues only when we are in a write state and the ex port is idle.
  always_comb begin
    w_write_state = (r_state == S_T_MEPC) || (r_state == S_T_MCAUSE) ||
                    (r_state == S_T_MSTATUS) || (r_state == S_M_MSTATUS);
    w_issue       = w_write_state && !ex_csr_we_i;
  end

  // MSTATUS edits use the live CSR value so a stalled write picks up ex-port updates.
  always_comb begin
    w_ms_trap    = csr_mstatus_i;
    w_ms_trap[7] = csr_mstatus_i[3];
    w_ms_trap[3] = 1'b0;
    w_ms_mret    = csr_mstatus_i;
    w_ms_mret[3] = csr_mstatus_i[7];
    w_ms_mret[7] = 1'b1;
  end

  // Trap target: direct base, or base + 4*cause for vectored interrupts when enabled.
  always_comb begin
    w_mtvec_base = csr_mtvec_i & ~DataWidth'(3);
`ifdef CSR_TRAP_VECTORED_EN
    if ((csr_mtvec_i[1:0] == 2'b01) && r_cause[DataWidth-1]) begin
      w_trap_tgt = w_mtvec_base + {r_cause[DataWidth-3:0], 2'b00};
    end else begin
      w_trap_tgt = w_mtvec_base;
    end
`else
    w_trap_tgt = w_mtvec_base;
`endif
  end

  // Address/data per write state; both forced to zero whenever no write issues.
  always_comb begin
    w_addr = 12'h000;
    w_data = '0;
    case (r_state)
      S_T_MEPC:    begin w_addr = A_MEPC;    w_data = r_pc;      end
      S_T_MCAUSE:  begin w_addr = A_MCAUSE;  w_data = r_cause;   end
      S_T_MSTATUS: begin w_addr = A_MSTATUS; w_data = w_ms_trap; end
      S_M_MSTATUS: begin w_addr = A_MSTATUS; w_data = w_ms_mret; end
      default:     begin w_addr = 12'h000;   w_data = '0;        end
    endcase
    if (!w_issue) begin
      w_addr = 12'h000;
      w_data = '0;
    end
  end

  // Sequencer: accept in IDLE (trap over mret), advance on each issued write, redirect for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cause    <= '0;
      r_pc       <= '0;
      r_redir_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trap_req_i) begin
            r_cause <= trap_cause_i;
            r_pc    <= trap_pc_i;
            r_state <= S_T_MEPC;
          end else if (mret_req_i) begin
            r_state <= S_M_MSTATUS;
          end
        end
        S_T_MEPC:   if (w_issue) r_state <= S_T_MCAUSE;
        S_T_MCAUSE: if (w_issue) r_state <= S_T_MSTATUS;
        S_T_MSTATUS: begin
          if (w_issue) begin
            r_redir_pc <= w_trap_tgt;
            r_state    <= S_REDIR;
          end
        end
        S_M_MSTATUS: begin
          if (w_issue) begin
            r_redir_pc <= csr_mepc_i;
            r_state    <= S_REDIR;
          end
        end
        S_REDIR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode; busy also reflects requests still waiting in IDLE.
  always_comb begin
    csr_we_o      = w_issue;
    csr_waddr_o   = AddrWidth'(w_addr);
    csr_wdata_o   = w_data;
    busy_o        = rst_ni && ((r_state != S_IDLE) || trap_req_i || mret_req_i);
    ack_o         = (r_state == S_REDIR);
    redirect_o    = (r_state == S_REDIR);
    redirect_pc_o = (r_state == S_REDIR) ? r_redir_pc : '0;
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed and randomized bench for csr_trap_seq against a write-list reference model.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Honours CSR_TRAP_VECTORED_EN for the expected trap target.
module tb_csr_trap_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        trap_req_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic        mret_req_i = 1'b0;
  logic        ex_csr_we_i = 1'b0;
  logic [31:0] csr_mtvec_i = '0;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = '0;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        busy_o;
  logic        ack_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int n_cmp = 0;
  int n_err = 0;

  csr_trap_seq #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .mret_req_i(mret_req_i), .ex_csr_we_i(ex_csr_we_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .busy_o(busy_o), .ack_o(ack_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Trap entry: MPIE takes MIE, MIE cleared.
  function automatic logic [31:0] ms_after_trap(input logic [31:0] ms);
    return (ms & 32'hFFFF_FF77) | (ms[3] ? 32'h80 : 32'h0);
  endfunction

  // mret: MIE takes MPIE, MPIE set.
  function automatic logic [31:0] ms_after_mret(input logic [31:0] ms);
    return (ms & 32'hFFFF_FFF7) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec - (mtvec % 4);
`ifdef CSR_TRAP_VECTORED_EN
    if ((mtvec % 4) == 1 && cause >= 32'h8000_0000) return base + 4 * (cause - 32'h8000_0000);
`endif
    return base;
  endfunction

  // Entered 1 unit after the falling edge of the acceptance cycle, with requests driven.
  // stall[c] drives ex_csr_we_i in cycle c after acceptance.
  task automatic run_seq(input bit is_trap, input logic [15:0] stall, input bit rand_ms,
                         input bit drop_trap, input bit drop_mret,
                         output int ack_cyc, output logic [31:0] seen_pc);
    logic [11:0] eaddr [3];
    logic [31:0] edat [3];
    logic [31:0] tgt;
    logic [31:0] exp_d;
    int nexp;
    int nw;
    bit done;
    chk("accept_we", {31'b0, csr_we_o}, 32'd0);
    chk("accept_busy", {31'b0, busy_o}, 32'd1);
    chk("accept_redirect", {31'b0, redirect_o}, 32'd0);
    edat[0] = '0; edat[1] = '0; edat[2] = '0;
    if (is_trap) begin
      eaddr[0] = 12'h341; edat[0] = trap_pc_i;
      eaddr[1] = 12'h342; edat[1] = trap_cause_i;
      eaddr[2] = 12'h300;
      nexp = 3;
      tgt = trap_target(csr_mtvec_i, trap_cause_i);
    end else begin
      eaddr[0] = 12'h300; eaddr[1] = 12'h0; eaddr[2] = 12'h0;
      nexp = 1;
      tgt = csr_mepc_i;
    end
    nw = 0; done = 1'b0; ack_cyc = -1; seen_pc = '0;
    for (int cyc = 1; cyc < 40 && !done; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) begin
        trap_pc_i = $urandom;
        trap_cause_i = $urandom;
      end
      ex_csr_we_i = (cyc < 16) ? stall[cyc] : 1'b0;
      if (rand_ms) csr_mstatus_i = $urandom;
      #1;
      chk("busy_mid", {31'b0, busy_o}, 32'd1);
      if (nw < nexp) begin
        chk("redirect_early", {31'b0, redirect_o}, 32'd0);
        chk("ack_early", {31'b0, ack_o}, 32'd0);
        if (ex_csr_we_i) begin
          chk("stall_we", {31'b0, csr_we_o}, 32'd0);
          chk("stall_addr", csr_waddr_o, 32'd0);
          chk("stall_data", csr_wdata_o, 32'd0);
        end else begin
          if (eaddr[nw] == 12'h300)
            exp_d = is_trap ? ms_after_trap(csr_mstatus_i) : ms_after_mret(csr_mstatus_i);
          else
            exp_d = edat[nw];
          chk("write_we", {31'b0, csr_we_o}, 32'd1);
          chk("write_addr", csr_waddr_o, {20'h0, eaddr[nw]});
          chk("write_data", csr_wdata_o, exp_d);
          nw++;
        end
      end else begin
        chk("redirect", {31'b0, redirect_o}, 32'd1);
        chk("ack", {31'b0, ack_o}, 32'd1);
        chk("redirect_pc", redirect_pc_o, tgt);
        chk("redir_we", {31'b0, csr_we_o}, 32'd0);
        seen_pc = redirect_pc_o;
        ack_cyc = cyc;
        done = 1'b1;
      end
    end
    chk("seq_completed", {31'b0, done}, 32'd1);
    @(negedge clk_i);
    ex_csr_we_i = 1'b0;
    if (drop_trap) trap_req_i = 1'b0;
    if (drop_mret) mret_req_i = 1'b0;
    #1;
    chk("ack_pulse_end", {31'b0, ack_o}, 32'd0);
    chk("redirect_pulse_end", {31'b0, redirect_o}, 32'd0);
    chk("redirect_pc_idle", redirect_pc_o, 32'd0);
    chk("idle_we", {31'b0, csr_we_o}, 32'd0);
    chk("idle_busy", {31'b0, busy_o}, {31'b0, trap_req_i | mret_req_i});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ackc;
    logic [31:0] pc_seen;
    bit is_trap;

    // Reset state
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_we", {31'b0, csr_we_o}, 32'd0);
    chk("rst_addr", csr_waddr_o, 32'd0);
    chk("rst_data", csr_wdata_o, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_redirect", {31'b0, redirect_o}, 32'd0);
    chk("rst_pc", redirect_pc_o, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Trap, no contention
    @(negedge clk_i);
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h100; trap_pc_i = 32'h2000; trap_cause_i = 32'hB;
    trap_req_i = 1'b1;
    #1;
    run_seq(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
    chk("trap_ack_cycle", ackc, 32'd4);
    chk("trap_target_lit", pc_seen, 32'h100);

    // mret
    @(negedge clk_i);
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h2004;
    mret_req_i = 1'b1;
    #1;
    run_seq(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ackc, pc_seen);
    chk("mret_ack_cycle", ackc, 32'd2);
    chk("mret_target_lit", pc_seen, 32'h2004);

    // Contention: ex writes during the two T_MCAUSE cycles
    @(negedge clk_i);
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h100; trap_pc_i = 32'h2000; trap_cause_i = 32'hB;
    trap_req_i = 1'b1;
    #1;
    run_seq(1'b1, 16'b0000_0000_0000_1100, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
    chk("contention_ack_cycle", ackc, 32'd6);

    // Simultaneous trap and mret: trap first, mret accepted right after REDIR
    @(negedge clk_i);
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200; csr_mepc_i = 32'h4444;
    trap_pc_i = 32'h3000; trap_cause_i = 32'h3;
    trap_req_i = 1'b1; mret_req_i = 1'b1;
    #1;
    run_seq(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
    chk("both_trap_ack_cycle", ackc, 32'd4);
    csr_mstatus_i = 32'h80;
    run_seq(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ackc, pc_seen);
    chk("both_mret_ack_cycle", ackc, 32'd2);

    // Reset asserted while in T_MCAUSE
    @(negedge clk_i);
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h100; trap_pc_i = 32'h5000; trap_cause_i = 32'h5;
    trap_req_i = 1'b1;
    @(negedge clk_i); #1;
    chk("pre_rst_mepc_addr", csr_waddr_o, 32'h341);
    @(negedge clk_i); #1;
    chk("pre_rst_mcause_addr", csr_waddr_o, 32'h342);
    rst_ni = 1'b0;
    #1;
    chk("midrst_we", {31'b0, csr_we_o}, 32'd0);
    chk("midrst_addr", csr_waddr_o, 32'd0);
    chk("midrst_data", csr_wdata_o, 32'd0);
    chk("midrst_ack", {31'b0, ack_o}, 32'd0);
    chk("midrst_redirect", {31'b0, redirect_o}, 32'd0);
    chk("midrst_pc", redirect_pc_o, 32'd0);
    @(negedge clk_i); #1;
    chk("midrst_hold_we", {31'b0, csr_we_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    run_seq(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
    chk("restart_ack_cycle", ackc, 32'd4);

    // Vectored-mode targets
    @(negedge clk_i);
    csr_mstatus_i = 32'h0; csr_mtvec_i = 32'h101; trap_pc_i = 32'h6000; trap_cause_i = 32'h8000_0007;
    trap_req_i = 1'b1;
    #1;
    run_seq(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
`ifdef CSR_TRAP_VECTORED_EN
    chk("vec_irq_target", pc_seen, 32'h11C);
`else
    chk("vec_irq_target", pc_seen, 32'h100);
`endif
    @(negedge clk_i);
    trap_pc_i = 32'h6004; trap_cause_i = 32'h2;
    trap_req_i = 1'b1;
    #1;
    run_seq(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, ackc, pc_seen);
    chk("vec_exc_target", pc_seen, 32'h100);

    // Randomized sequences with random stalls and a changing mstatus
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      is_trap = 1'($urandom_range(0, 1));
      trap_pc_i = $urandom; trap_cause_i = $urandom;
      csr_mtvec_i = $urandom; csr_mepc_i = $urandom; csr_mstatus_i = $urandom;
      if (is_trap) trap_req_i = 1'b1; else mret_req_i = 1'b1;
      #1;
      run_seq(is_trap, 16'($urandom & $urandom), 1'b1, 1'b1, 1'b1, ackc, pc_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
